// File: rtl/cp0_timer_irq_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause bit positions and
// exception codes, used by the CP0, the instruction decoder and the hazard unit.
package cp0_pkg;

    typedef enum logic [4:0] {
        REG_COUNT   = 5'd9,
        REG_COMPARE = 5'd11,
        REG_SR      = 5'd12,
        REG_CAUSE   = 5'd13,
        REG_EPC     = 5'd14,
        REG_PRID    = 5'd15
    } cp0_reg_e;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // SR bit positions
    localparam int unsigned SR_IE     = 0;
    localparam int unsigned SR_EXL    = 1;
    localparam int unsigned SR_IM_LO  = 8;
    localparam int unsigned SR_IM_HI  = 15;

    // Cause bit positions
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_SW_LO  = 8;
    localparam int unsigned CAUSE_SW_HI  = 9;
    localparam int unsigned CAUSE_HW_LO  = 10;
    localparam int unsigned CAUSE_HW_HI  = 15;
    localparam int unsigned CAUSE_TI     = 30;
    localparam int unsigned CAUSE_BD     = 31;

endpackage

// File: rtl/cp0_timer_irq_if.sv
// CP0 <-> M-stage bus: mtc0/mfc0 access, exception inputs and redirect outputs.
interface cp0_timer_irq_if #(
    parameter int NUM_HWINT = 6
);
    logic                 we;
    logic [4:0]           addr;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic [31:0]          vpc;
    logic                 bd_in;
    logic [4:0]           exc_code_in;
    logic [NUM_HWINT-1:0] hw_int;
    logic                 exl_clr;
    logic [31:0]          epc_out;
    logic                 req;
    logic                 timer_irq;

    modport master (
        output we, addr, wdata, vpc, bd_in, exc_code_in, hw_int, exl_clr,
        input  rdata, epc_out, req, timer_irq
    );

    modport slave (
        input  we, addr, wdata, vpc, bd_in, exc_code_in, hw_int, exl_clr,
        output rdata, epc_out, req, timer_irq
    );
endinterface

// File: rtl/cp0_timer_irq_count_timer.sv
// Count/Compare timer: prescaler, free-running Count, Compare and the TI flag.
module cp0_count_timer #(
    parameter bit          TIMER_EN  = 1'b1,
    parameter int unsigned COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_count,
    input  logic        write_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] presc;
    logic [31:0]   count_q;
    logic [31:0]   compare_q;
    logic          ti_q;
    logic          tick;
    logic [31:0]   count_inc;

    assign tick      = (presc == PW'(COUNT_DIV - 1));
    assign count_inc = count_q + 32'd1;

    // Prescaler and Count; an mtc0 load restarts the prescaler
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc   <= '0;
            count_q <= '0;
        end else if (load_count) begin
            presc   <= '0;
            count_q <= wdata;
        end else if (tick) begin
            presc   <= '0;
            count_q <= count_inc;
        end else begin
            presc   <= presc + PW'(1);
        end
    end

    // Compare and TI; TI only rises on a real increment onto Compare
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else if (write_compare) begin
            compare_q <= wdata;
            ti_q      <= 1'b0;
        end else if (!load_count && tick && (count_inc == compare_q)) begin
            ti_q      <= 1'b1;
        end
    end

    assign count   = TIMER_EN ? count_q   : '0;
    assign compare = TIMER_EN ? compare_q : '0;
    assign ti      = TIMER_EN ? ti_q      : 1'b0;

endmodule

// File: rtl/cp0_timer_irq.sv
// CP0 at the M stage: SR/Cause/EPC/PRId, exception/interrupt request and
// redirect EPC, with a Count/Compare timer feeding IP[15].
module cp0_timer_irq
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter bit          TIMER_EN  = 1'b1,
    parameter int unsigned COUNT_DIV = 1,
    parameter logic [31:0] PRID      = 32'h0000_7000
) (
    input  logic           clk,
    input  logic           reset,
    cp0_timer_irq_if.slave bus
);

    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic [5:0]  hw6;
    logic [7:0]  ip_live;
    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] epc_next;
    logic        wr_en;
    logic        load_count;
    logic        write_compare;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    cp0_count_timer #(
        .TIMER_EN  (TIMER_EN),
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .load_count    (load_count),
        .write_compare (write_compare),
        .wdata         (bus.wdata),
        .count         (count),
        .compare       (compare),
        .ti            (ti)
    );

    // Zero-extend the hardware lines to the full six IP[15:10] slots
    always_comb begin
        hw6                = '0;
        hw6[NUM_HWINT-1:0] = bus.hw_int;
    end

    assign ip_live  = {hw6[5] | ti, hw6[4:0], ip_sw};
    assign int_req  = !exl && ie && |(im & ip_live);
    assign exc_req  = !exl && (bus.exc_code_in != '0);
    assign req      = int_req || exc_req;
    assign epc_next = bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;

    // A taken exception/interrupt swallows the mtc0 in the same cycle
    assign wr_en         = bus.we && !req;
    assign load_count    = wr_en && (bus.addr == REG_COUNT);
    assign write_compare = wr_en && (bus.addr == REG_COMPARE);

    assign sr_val    = {16'h0000, im, 6'b000000, exl, ie};
    assign cause_val = {bd, ti, 14'h0000, ip_hw, ip_sw, 1'b0, exc_code, 2'b00};

    assign bus.req       = req;
    assign bus.epc_out   = req ? epc_next : epc;
    assign bus.timer_irq = ti;

    // mfc0 read mux
    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            REG_COUNT:   bus.rdata = count;
            REG_COMPARE: bus.rdata = compare;
            REG_SR:      bus.rdata = sr_val;
            REG_CAUSE:   bus.rdata = cause_val;
            REG_EPC:     bus.rdata = epc;
            REG_PRID:    bus.rdata = PRID;
            default:     bus.rdata = '0;
        endcase
    end

    // SR/Cause/EPC update: exception entry first, else eret and mtc0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip_hw    <= '0;
            ip_sw    <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip_hw <= ip_live[7:2];
            if (req) begin
                exl      <= 1'b1;
                bd       <= bus.bd_in;
                exc_code <= int_req ? EXC_INT : bus.exc_code_in;
                epc      <= epc_next;
            end else begin
                if (bus.exl_clr) begin
                    exl <= 1'b0;
                end
                if (bus.we && (bus.addr == REG_SR)) begin
                    im  <= bus.wdata[SR_IM_HI:SR_IM_LO];
                    exl <= bus.wdata[SR_EXL];
                    ie  <= bus.wdata[SR_IE];
                end
                if (bus.we && (bus.addr == REG_CAUSE)) begin
                    ip_sw <= bus.wdata[CAUSE_SW_HI:CAUSE_SW_LO];
                end
                if (bus.we && (bus.addr == REG_EPC)) begin
                    epc <= bus.wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_timer_irq.sv
// Scoreboard bench for cp0_timer_irq: directed scenarios plus random traffic,
// checked against a behavioural CP0 model.
module tb_cp0_timer_irq;

    localparam int unsigned CDIV   = 1;
    localparam logic [31:0] PRID_V = 32'h0000_7000;

    typedef struct {
        string       nm;
        logic        rq;
        logic [31:0] epc;
        logic [31:0] rd;
        logic        ti;
        bit          frd_en;
        logic [31:0] frd;
        bit          frq_en;
        logic        frq;
        bit          fep_en;
        logic [31:0] fep;
    } item_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cp0_timer_irq_if #(.NUM_HWINT(6)) bus ();

    cp0_timer_irq #(
        .NUM_HWINT (6),
        .TIMER_EN  (1'b1),
        .COUNT_DIV (CDIV),
        .PRID      (PRID_V)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    item_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model state: Count is derived from a load value and elapsed clocks
    logic [31:0]     m_base;
    longint unsigned m_elapsed;
    logic [31:0]     m_cmp;
    logic            m_ti;
    logic [7:0]      m_im;
    logic            m_exl, m_ie, m_bd;
    logic [5:0]      m_iphw;
    logic [1:0]      m_sw;
    logic [4:0]      m_exc;
    logic [31:0]     m_epc;

    // Optional absolute expectations attached to the next step
    bit          fx_rd_en = 0;
    logic [31:0] fx_rd    = '0;
    bit          fx_rq_en = 0;
    logic        fx_rq    = 1'b0;
    bit          fx_ep_en = 0;
    logic [31:0] fx_ep    = '0;

    task automatic model_reset();
        m_base = '0; m_elapsed = 0; m_cmp = '0; m_ti = 1'b0;
        m_im = '0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
        m_iphw = '0; m_sw = '0; m_exc = '0; m_epc = '0;
    endtask

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: one expected response per cycle, compared mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                item_t it;
                it = q.pop_front();
                cmp({it.nm, ".req"},   32'(bus.req),       32'(it.rq));
                cmp({it.nm, ".epc"},   bus.epc_out,        it.epc);
                cmp({it.nm, ".rdata"}, bus.rdata,          it.rd);
                cmp({it.nm, ".ti"},    32'(bus.timer_irq), 32'(it.ti));
                if (it.frd_en) cmp({it.nm, ".rdata_abs"}, bus.rdata,    it.frd);
                if (it.frq_en) cmp({it.nm, ".req_abs"},   32'(bus.req), 32'(it.frq));
                if (it.fep_en) cmp({it.nm, ".epc_abs"},   bus.epc_out,  it.fep);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached with %0d items pending", q.size());
        $fatal(1, "watchdog");
    end

    // Drive one cycle, push its expected response, then advance the model
    task automatic step(input bit r, input bit w, input logic [4:0] a, input logic [31:0] wd,
                        input logic [31:0] pc, input bit bdi, input logic [4:0] ec,
                        input logic [5:0] hw, input bit clr, input string nm);
        item_t           it;
        logic [31:0]     cnt, ncnt, cause, rdv, epcn;
        logic [7:0]      ipl;
        logic            ireq, ereq, rq, wrok, tick;
        longint unsigned el1;

        @(posedge clk);
        #1;
        reset = r;
        bus.we = w; bus.addr = a; bus.wdata = wd; bus.vpc = pc; bus.bd_in = bdi;
        bus.exc_code_in = ec; bus.hw_int = hw; bus.exl_clr = clr;
        if (r) model_reset();

        cnt   = m_base + 32'(m_elapsed / CDIV);
        ipl   = {hw[5] | m_ti, hw[4:0], m_sw};
        ireq  = !m_exl && m_ie && ((m_im & ipl) != 8'h00);
        ereq  = !m_exl && (ec != 5'd0);
        rq    = ireq || ereq;
        epcn  = bdi ? pc - 32'd4 : pc;
        cause = {m_bd, m_ti, 14'h0, m_iphw, m_sw, 1'b0, m_exc, 2'b00};
        case (a)
            5'd9:    rdv = cnt;
            5'd11:   rdv = m_cmp;
            5'd12:   rdv = {16'h0, m_im, 6'h0, m_exl, m_ie};
            5'd13:   rdv = cause;
            5'd14:   rdv = m_epc;
            5'd15:   rdv = PRID_V;
            default: rdv = '0;
        endcase

        it.nm = nm; it.rq = rq; it.epc = rq ? epcn : m_epc; it.rd = rdv; it.ti = m_ti;
        it.frd_en = fx_rd_en; it.frd = fx_rd;
        it.frq_en = fx_rq_en; it.frq = fx_rq;
        it.fep_en = fx_ep_en; it.fep = fx_ep;
        q.push_back(it);
        fx_rd_en = 0; fx_rq_en = 0; fx_ep_en = 0;

        if (!r) begin
            el1    = m_elapsed + 1;
            tick   = (el1 % CDIV) == 0;
            ncnt   = m_base + 32'(el1 / CDIV);
            m_iphw = ipl[7:2];
            wrok   = w && !rq;
            if (wrok && a == 5'd9) begin
                m_base = wd; m_elapsed = 0;
            end else begin
                m_elapsed = el1;
                if (tick && ncnt == m_cmp) m_ti = 1'b1;
            end
            if (wrok && a == 5'd11) begin
                m_cmp = wd; m_ti = 1'b0;
            end
            if (rq) begin
                m_exl = 1'b1; m_bd = bdi; m_exc = ireq ? 5'd0 : ec; m_epc = epcn;
            end else begin
                if (clr) m_exl = 1'b0;
                if (w && a == 5'd12) begin m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0]; end
                if (w && a == 5'd13) m_sw = wd[9:8];
                if (w && a == 5'd14) m_epc = wd;
            end
        end
    endtask

    task automatic rd(input logic [4:0] a, input string nm);
        step(0, 0, a, '0, 32'h100, 0, '0, '0, 0, nm);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] wd, input string nm);
        step(0, 1, a, wd, 32'h100, 0, '0, '0, 0, nm);
    endtask

    task automatic eret(input string nm);
        step(0, 0, 5'd12, '0, 32'h100, 0, '0, '0, 1, nm);
    endtask

    function automatic logic [31:0] fix(input logic [31:0] v);
        fx_rd_en = 1; fx_rd = v;
        return v;
    endfunction

    initial begin
        logic [31:0] dummy;
        logic [4:0]  alist [7];
        logic [4:0]  elist [4];
        alist = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        elist = '{5'd4, 5'd5, 5'd10, 5'd12};
        model_reset();
        bus.we = 0; bus.addr = '0; bus.wdata = '0; bus.vpc = '0; bus.bd_in = 0;
        bus.exc_code_in = '0; bus.hw_int = '0; bus.exl_clr = 0;

        // Reset state
        dummy = fix(32'h0000_7000);
        step(1, 0, 5'd15, '0, '0, 0, '0, '0, 0, "rst_prid");
        dummy = fix(32'h0);  rd(5'd12, "rst_sr");
        dummy = fix(32'h0);  rd(5'd13, "rst_cause");
        dummy = fix(32'h0);  rd(5'd14, "rst_epc");
        dummy = fix(32'h0000_7000); rd(5'd15, "prid");

        // Hardware interrupt in a delay slot
        wr(5'd12, 32'h0000_0401, "sr_hw0");
        fx_rq_en = 1; fx_rq = 1'b1; fx_ep_en = 1; fx_ep = 32'h0000_3004;
        step(0, 0, 5'd13, '0, 32'h3008, 1, '0, 6'b000001, 0, "hwint_take");
        fx_rq_en = 1; fx_rq = 1'b0; dummy = fix(32'h8000_0400);
        step(0, 0, 5'd13, '0, 32'h3010, 0, '0, 6'b000001, 0, "hwint_cause");
        dummy = fix(32'h0000_0403); rd(5'd12, "hwint_sr");

        // Interrupt outranks a simultaneous exception; eret clears EXL
        eret("eret1");
        fx_rq_en = 1; fx_rq = 1'b1;
        step(0, 0, 5'd13, '0, 32'h4000, 0, 5'd12, 6'b000001, 0, "int_vs_ov");
        dummy = fix(32'h0000_0400); rd(5'd13, "int_vs_ov_cause");
        eret("eret2");
        dummy = fix(32'h0000_0401); rd(5'd12, "eret_sr");

        // Timer match with COUNT_DIV=1
        wr(5'd12, 32'h0000_8001, "sr_timer");
        wr(5'd11, 32'd5, "cmp5");
        wr(5'd9, 32'd0, "cnt0");
        for (int i = 0; i < 8; i++) begin
            dummy = fix(32'(i));
            if (i == 5) begin fx_rq_en = 1; fx_rq = 1'b1; end
            rd(5'd9, $sformatf("count_%0d", i));
        end
        wr(5'd11, 32'd100, "cmp_clear_ti");
        eret("eret3");
        fx_rq_en = 1; fx_rq = 1'b0; rd(5'd13, "ti_cleared");
        wr(5'd12, 32'h0, "sr_off");

        // Software interrupt and Cause write mask
        wr(5'd12, 32'h0000_0101, "sr_sw");
        wr(5'd13, 32'h0000_0100, "cause_sw");
        fx_rq_en = 1; fx_rq = 1'b1; rd(5'd13, "sw_take");
        dummy = fix(32'h0000_0100); rd(5'd13, "sw_cause");
        wr(5'd13, 32'h0, "sw_clr");
        wr(5'd13, 32'hFFFF_FFFF, "cause_ones");
        dummy = fix(32'h0000_0300); rd(5'd13, "cause_mask");
        wr(5'd13, 32'h0, "sw_clr2");
        eret("eret4");
        wr(5'd12, 32'h0, "sr_off2");

        // Reset between increment and match
        wr(5'd11, 32'd20, "cmp20");
        wr(5'd9, 32'd0, "cnt0b");
        for (int i = 0; i < 5; i++) rd(5'd9, "pre_rst");
        dummy = fix(32'h0);
        step(1, 0, 5'd9, '0, '0, 0, '0, '0, 0, "mid_rst_count");
        dummy = fix(32'h0);
        step(1, 0, 5'd13, '0, '0, 0, '0, '0, 0, "mid_rst_cause");
        for (int i = 0; i < 25; i++) rd(5'd9, "post_rst");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [4:0]  a, ec;
            logic [31:0] wd;
            logic [5:0]  hw;
            bit          w, clr;
            a   = alist[$urandom_range(0, 6)];
            w   = ($urandom_range(0, 3) == 0);
            wd  = $urandom;
            if (a == 5'd11) wd = (m_base + 32'(m_elapsed / CDIV)) + 32'($urandom_range(1, 8));
            if (a == 5'd9 && $urandom_range(0, 1) == 1) wd = m_cmp - 32'($urandom_range(1, 6));
            hw  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h0;
            ec  = ($urandom_range(0, 15) == 0) ? elist[$urandom_range(0, 3)] : 5'd0;
            clr = m_exl && ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 199) == 0), w, a, wd, {$urandom} & 32'hFFFF_FFFC,
                 $urandom_range(0, 1) == 1, ec, hw, clr, "rand");
        end

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d items left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_timer_irq.md
# cp0_timer_irq

Parametrised second-generation MIPS coprocessor 0 for the pipelined CPU, sitting at the M stage alongside data memory. It adds four things to the base SR/Cause/EPC exception/interrupt unit:
- a Count/Compare timer
- two software-interrupt bits
- a read-only PRId register
- a configurable number of hardware interrupt lines

It decides each cycle whether the instruction in M is flushed and the PC redirected to the handler, and it supplies the EPC value for that redirect.

## Interface
Parameters:
- NUM_HWINT, 6, number of hardware interrupt lines (1..6), mapped to IP[10+i].
- TIMER_EN, 1, 1 = Count/Compare present; 0 = Count/Compare read 0, writes ignored, TI never set.
- COUNT_DIV, 1, Count increments once every COUNT_DIV clocks (≥1).
- PRID, 32'h0000_7000, constant returned by register 15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  mtc0 write enable.
- addr  in  5  CP0 register number for mtc0/mfc0.
- wdata  in  32  mtc0 write data.
- rdata  out  32  mfc0 read data (combinational).
- vpc  in  32  PC of the M-stage instruction.
- bd_in  in  1  M-stage instruction is in a delay slot.
- exc_code_in  in  5  M-stage exception code; 0 = none.
- hw_int  in  NUM_HWINT  level-sensitive device interrupts.
- exl_clr  in  1  eret in M: clear EXL.
- epc_out  out  32  EPC value for eret/redirect (combinational).
- req  out  1  take exception/interrupt this cycle (combinational).
- timer_irq  out  1  Cause.TI, for debug/observation.

## Operation
Registers, with writable fields; all other bits read 0:
- Count (9), Compare (11): full 32 bits.
- SR (12): IM[15:8], EXL[1], IE[0].
- Cause (13): BD[31], TI[30] (RO), IP[15:10] (RO), IP[9:8] (software, RW), ExcCode[6:2] (RO).
- EPC (14): 32 bits.
- PRId (15): read-only, returns PRID.
- Any other address reads 0; writes to it are ignored.

Pending vector ip_live[15:8]:
- [8], [9] = software bits.
- [10+i] = hw_int[i], taken live (unregistered).
- [15] additionally ORs in TI when TIMER_EN.

Request logic:
- int_req = !EXL & IE & |(IM & ip_live).
- exc_req = !EXL & (exc_code_in != 0).
- req = int_req | exc_req.

On a clock edge with req:
- EXL ← 1, BD ← bd_in.
- ExcCode ← 0 if int_req, else exc_code_in. An interrupt outranks a simultaneous exception.
- EPC ← bd_in ? vpc−4 : vpc.
- The mtc0 write in the same cycle is dropped.

Otherwise, if we, the addressed register is written. exl_clr clears EXL; if we targets SR in the same cycle, the written value wins.

epc_out = (req ? (bd_in ? vpc−4 : vpc) : EPC), so a handler redirect and eret use the same port.

Cause.IP[15:10] is resampled from the lines feeding ip_live[15:10] every cycle, unconditionally, and holds the value from the previous cycle.

Timer (TIMER_EN=1):
- A prescaler counts 0..COUNT_DIV−1; Count increments, wrapping modulo 2^32, when the prescaler wraps.
- TI sets on the edge where Count increments to a value equal to Compare.
- A Count == Compare state produced by reset or by an mtc0 load never sets TI.
- Writing Compare clears TI.
- Writing Count loads wdata and zeroes the prescaler.
- TI persists across req, eret, and IE/IM changes.

## Timing
- Reset (async): all registers 0, prescaler 0. Outputs: req 0, epc_out 0, rdata per addr (0 except PRId), timer_irq 0.
- req, epc_out and rdata are same-cycle combinational. Register effects are visible from the next cycle.
- mfc0 of a register written by mtc0 in the same cycle returns the old value.
- Count read at cycle t after reset with COUNT_DIV=1 returns t.
- TI is visible one cycle after the matching increment. It then drives int_req immediately if unmasked.
- Reset asserted mid-handler clears EXL and TI immediately, without waiting for an edge.

## Structure
- Package cp0_pkg holds the following, shared with the decoder and the hazard unit:
  - register numbers: COUNT, COMPARE, SR, CAUSE, EPC, PRID;
  - SR/Cause bit positions;
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
- One sub-module, cp0_count_timer, holds prescaler, Count, Compare and TI. Its interface is load/compare-write strobes plus wdata, with outputs count, compare and ti.

## Test plan
- Reset, then read addr 15 -> rdata = 32'h0000_7000; SR, Cause and EPC read 0; req = 0.
- SR = 32'h0000_0401, hw_int[0]=1, vpc=0x3008, bd_in=1 -> req=1 and epc_out=0x3004 in the same cycle. Next cycle: Cause = 0x8000_0400 (BD=1, IP[10]=1, ExcCode=0), SR.EXL=1, req=0.
- exc_code_in=12 with an enabled hw_int in the same cycle -> ExcCode=0. Then exl_clr=1 -> EXL=0 next cycle.
- COUNT_DIV=1: write Compare=5, write Count=0 -> TI=1 exactly at Count=5. With SR=0x8001, req asserts. Writing Compare clears TI and req.
- Write Cause=0x0000_0100 with SR=0x0101 -> software interrupt: req=1, ExcCode=0. A Cause write of 0xFFFF_FFFF changes only IP[9:8].
- Assert reset between a Count increment and the Compare match -> Count=0 and TI=0 immediately; no spurious TI after deassert until Count reaches Compare again.
